// File: rtl/jtframe_prom_dwnld.sv
// Download router: classifies each ioctl byte into MAIN/MAP/GFX/PROM and either queues
// a remapped 16-bit SDRAM byte write (2-entry buffer, ready handshake) or strobes a PROM bank.
module jtframe_prom_dwnld #(
  parameter int              AW         = 22,
  parameter logic [AW-1:0]   MAP_START  = 22'h38000,
  parameter logic [AW-1:0]   GFX_START  = 22'h48000,
  parameter logic [AW-1:0]   PROM_START = 22'hD8000,
  parameter int              SPLIT_BIT  = 15,
  parameter int              PROM_CNT   = 12,
  parameter int              PROM_AW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [AW-2:0]       prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  input  logic                prog_rdy,
  output logic [PROM_CNT-1:0] prom_we,
  output logic [PROM_AW-1:0]  prom_addr,
  output logic [7:0]          prom_data,
  output logic                ovf,
  output logic                done
);

  typedef struct packed {
    logic [AW-2:0] addr;
    logic [7:0]    data;
    logic [1:0]    mask;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam entry_t        ENTRY_RST = '{addr: '0, data: 8'h00, mask: 2'b11};
  localparam logic [AW-2:0] MAP_WBASE = MAP_START[AW-1:1];
  localparam logic [AW-2:0] GFX_WBASE = GFX_START[AW-1:1];

  logic [AW-1:0] map_off, gfx_off, prom_off;
  logic [3:0]    prom_sel;
  logic          is_prom, wr_en, push_req, push_ok, pop, drop;
  logic          unused_prom_bits;
  entry_t        dec;
  logic [PROM_CNT-1:0] strobe;

  entry_t       e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         ovf_q, ovf_d, dl_q;
  logic [PROM_CNT-1:0] prom_we_q;
  logic [PROM_AW-1:0]  prom_addr_q;
  logic [7:0]          prom_data_q;
  state_t       state_q, state_d;

  assign map_off          = ioctl_addr - MAP_START;
  assign gfx_off          = ioctl_addr - GFX_START;
  assign prom_off         = ioctl_addr - PROM_START;
  assign prom_sel         = prom_off[PROM_AW+3:PROM_AW];
  assign unused_prom_bits = ^prom_off[AW-1:PROM_AW+4];

  // Region priority: PROM, GFX, MAP, then MAIN as the fallback.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    is_prom  = 1'b0;
    dec.addr = ioctl_addr[AW-1:1];
    dec.data = ioctl_data;
    dec.mask = {ioctl_addr[0], ~ioctl_addr[0]};
    if (ioctl_addr >= PROM_START) begin
      is_prom = 1'b1;
    end else if (ioctl_addr >= GFX_START) begin
      dec.addr = GFX_WBASE + {gfx_off[AW-1:SPLIT_BIT+1], gfx_off[SPLIT_BIT-1:0]};
      dec.mask = {gfx_off[SPLIT_BIT], ~gfx_off[SPLIT_BIT]};
    end else if (ioctl_addr >= MAP_START) begin
      dec.addr = MAP_WBASE + {map_off[AW-1:5], map_off[3:1], map_off[4]};
      dec.mask = {map_off[0], ~map_off[0]};
    end
  end

  always_comb begin
    strobe = '0;
    for (int i = 0; i < PROM_CNT; i++)
      strobe[i] = wr_en && is_prom && (prom_sel == 4'(i));
  end

  assign wr_en    = downloading && ioctl_wr;
  assign push_req = wr_en && !is_prom;
  assign pop      = (count_q != 2'd0) && prog_rdy;
  assign push_ok  = push_req && ((count_q != 2'd2) || pop);
  assign drop     = push_req && !push_ok;

  // e0 is always the head; a simultaneous push and pop keeps the count.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b01: begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) e0_d = dec;
        else                 e1_d = dec;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          e0_d = dec;
        end else begin
          e0_d = e1_q;
          e1_d = dec;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (downloading && !dl_q) ovf_d = 1'b0;
    if (drop)                 ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: buffer storage is reset too, because the head entry drives prog_* directly.
      e0_q        <= ENTRY_RST;
      e1_q        <= ENTRY_RST;
      count_q     <= 2'd0;
      ovf_q       <= 1'b0;
      dl_q        <= 1'b0;
      prom_we_q   <= '0;
      prom_addr_q <= '0;
      prom_data_q <= 8'h00;
    end else begin
      e0_q      <= e0_d;
      e1_q      <= e1_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      dl_q      <= downloading;
      prom_we_q <= strobe;
      if (wr_en && is_prom) begin
        prom_addr_q <= prom_off[PROM_AW-1:0];
        prom_data_q <= ioctl_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (downloading) state_d = LOAD;
      LOAD:  if (!downloading) state_d = DRAIN;
      DRAIN: begin
        if (downloading)                            state_d = LOAD;
        else if (count_q == 2'd0 && !push_ok)       state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done = (state_q == DONE);
  end

  assign prog_addr = e0_q.addr;
  assign prog_data = e0_q.data;
  assign prog_mask = e0_q.mask;
  assign prog_we   = (count_q != 2'd0);
  assign prom_we   = prom_we_q;
  assign prom_addr = prom_addr_q;
  assign prom_data = prom_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_jtframe_prom_dwnld.sv
// Scoreboard bench for jtframe_prom_dwnld: directed writes push hand-computed expectations,
// a negedge monitor pops them whenever the DUT presents an SDRAM transfer or PROM strobe.
module tb_jtframe_prom_dwnld;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr, prog_rdy;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [20:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [11:0] prom_we;
  logic [7:0]  prom_addr, prom_data;
  logic        ovf, done;

  typedef struct {
    logic [20:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } sd_t;

  typedef struct {
    logic [11:0] we;
    logic [7:0]  addr;
    logic [7:0]  data;
  } pr_t;

  sd_t sd_q[$];
  pr_t pr_q[$];
  sd_t sd_e;
  pr_t pr_e;
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;

  jtframe_prom_dwnld dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rdy(prog_rdy),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic exp_sd(input logic [20:0] a, input logic [7:0] d, input logic [1:0] m);
    sd_t e;
    e.addr = a; e.data = d; e.mask = m;
    sd_q.push_back(e);
  endtask

  // Monitor: every accepted SDRAM transfer and every PROM strobe consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (prog_we && prog_rdy) begin
        check("sd_expected_pending", 32'(sd_q.size() != 0), 32'd1);
        if (sd_q.size() != 0) begin
          sd_e = sd_q.pop_front();
          check("sd_addr", 32'(prog_addr), 32'(sd_e.addr));
          check("sd_data", 32'(prog_data), 32'(sd_e.data));
          check("sd_mask", 32'(prog_mask), 32'(sd_e.mask));
        end
      end
      if (prom_we != 12'h000) begin
        check("prom_expected_pending", 32'(pr_q.size() != 0), 32'd1);
        if (pr_q.size() != 0) begin
          pr_e = pr_q.pop_front();
          check("prom_we", 32'(prom_we), 32'(pr_e.we));
          check("prom_addr", 32'(prom_addr), 32'(pr_e.addr));
          check("prom_data", 32'(prom_data), 32'(pr_e.data));
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int found;
    pr_t p;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b1;
    ioctl_addr = '0; ioctl_data = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_prog_addr", 32'(prog_addr), 32'h0);
    check("rst_prog_data", 32'(prog_data), 32'h0);
    check("rst_prog_mask", 32'(prog_mask), 32'h3);
    check("rst_prog_we", 32'(prog_we), 32'h0);
    check("rst_prom_we", 32'(prom_we), 32'h0);
    check("rst_prom_addr", 32'(prom_addr), 32'h0);
    check("rst_prom_data", 32'(prom_data), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // 1: MAIN odd byte, one-cycle latency, drained immediately
    @(posedge clk); #1;
    rst = 1'b0; downloading = 1'b1;
    tick();
    exp_sd(21'h000000, 8'h5A, 2'b10);
    wr(22'h000001, 8'h5A);
    @(negedge clk);
    check("t1_we", 32'(prog_we), 32'h1);
    check("t1_addr", 32'(prog_addr), 32'h0);
    check("t1_mask", 32'(prog_mask), 32'h2);
    @(negedge clk);
    check("t1_we_after", 32'(prog_we), 32'h0);

    // 2: MAP and GFX remaps
    @(posedge clk); #1;
    exp_sd(21'h1C001, 8'h11, 2'b01);
    wr(22'h038010, 8'h11);
    exp_sd(21'h24002, 8'h22, 2'b10);
    wr(22'h050002, 8'h22);
    tick(); tick();

    // 3: PROM strobe, then out-of-range bank
    p.we = 12'h008; p.addr = 8'h45; p.data = 8'h7E;
    pr_q.push_back(p);
    wr(22'h0D8345, 8'h7E);
    @(negedge clk);
    check("t3_prom_we", 32'(prom_we), 32'h008);
    check("t3_prog_we", 32'(prog_we), 32'h0);
    @(negedge clk);
    check("t3_prom_we_1cyc", 32'(prom_we), 32'h0);
    @(posedge clk); #1;
    wr(22'h0D8C00, 8'h33);
    @(negedge clk);
    check("t3_bank12_no_we", 32'(prom_we), 32'h0);
    check("t3_bank12_no_prog", 32'(prog_we), 32'h0);

    // 4: backpressure, overflow, ordered drain, sticky ovf
    @(posedge clk); #1;
    prog_rdy = 1'b0;
    exp_sd(21'h000080, 8'hA1, 2'b01);
    wr(22'h000100, 8'hA1);
    exp_sd(21'h000080, 8'hA2, 2'b10);
    wr(22'h000101, 8'hA2);
    wr(22'h000202, 8'hA3);
    @(negedge clk);
    check("t4_ovf", 32'(ovf), 32'h1);
    check("t4_hold_we", 32'(prog_we), 32'h1);
    tick(); tick();
    @(negedge clk);
    check("t4_stable_addr", 32'(prog_addr), 32'h80);
    check("t4_stable_data", 32'(prog_data), 32'hA1);
    check("t4_stable_mask", 32'(prog_mask), 32'h1);
    @(posedge clk); #1;
    prog_rdy = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("t4_empty", 32'(prog_we), 32'h0);
    check("t4_ovf_sticky", 32'(ovf), 32'h1);
    @(posedge clk); #1;
    downloading = 1'b0;
    d0 = done_cnt;
    repeat (6) tick();
    check("t4_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("t4_ovf_after_end", 32'(ovf), 32'h1);
    downloading = 1'b1;
    tick();
    @(negedge clk);
    check("t4_ovf_cleared", 32'(ovf), 32'h0);

    // 5: done waits for the buffer to drain
    @(posedge clk); #1;
    prog_rdy = 1'b0;
    exp_sd(21'h001FF8, 8'hC1, 2'b01);
    wr(22'h003FF0, 8'hC1);
    exp_sd(21'h001FF8, 8'hC2, 2'b10);
    wr(22'h003FF1, 8'hC2);
    downloading = 1'b0;
    d0 = done_cnt;
    repeat (4) tick();
    check("t5_no_done_while_full", 32'(done_cnt), 32'(d0));
    prog_rdy = 1'b1;
    found = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done && found == 0) found = k;
    end
    check("t5_done_cycle", 32'(found), 32'd4);
    check("t5_done_single", 32'(done_cnt), 32'(d0 + 1));

    // 6: reset discards buffered entries
    @(posedge clk); #1;
    downloading = 1'b1; prog_rdy = 1'b0;
    tick();
    wr(22'h000010, 8'hD1);
    wr(22'h000011, 8'hD2);
    @(negedge clk);
    check("t6_buffered", 32'(prog_we), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_flushed", 32'(prog_we), 32'h0);
    rst = 1'b0; downloading = 1'b0; prog_rdy = 1'b1;
    d0 = done_cnt;
    repeat (5) tick();
    check("t6_no_done", 32'(done_cnt), 32'(d0));
    check("t6_still_empty", 32'(prog_we), 32'h0);

    check("sd_queue_drained", 32'(sd_q.size()), 32'd0);
    check("prom_queue_drained", 32'(pr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
